uart_tx9: RTL and testbench

Serializing UART transmitter for 9-bit ATC messages: the transmit end of the link whose receive side feeds Bob's request FIFO. It accepts parallel 9-bit reply words from the controller's `uart_tx_data` / `uart_tx_en` strobe and buffers them in a small FIFO. Each word goes out on a single serial line as an 8N1-style frame extended to 9 data bits, with optional parity. Bob's strobe has no back-pressure, so the block absorbs bursts and flags any word it has to drop.

---
 rtl/uart_tx9.sv | 165 ++++++++++++++++
 tb/tb_uart_tx9.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx9.sv
// Serial transmitter for 9-bit ATC reply words: a small holding FIFO feeding a
// start / 9 data / optional odd parity / stop framer on a single idle-high line.
module uart_tx9 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] tx_data,
  input  logic       tx_en,
  input  logic       clr_overflow,
  output logic       tx_serial,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          parity_bit;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic fifo_empty;
  logic fifo_full;
  logic bit_done;
  logic pop;
  logic push;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign bit_done   = (cyc_cnt == CYC_LAST);
  // A pop frees a slot on the same edge, so a write to a full FIFO still lands.
  assign pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign push = tx_en && (!fifo_full || pop);
  assign full = fifo_full;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dropped word wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clock) begin
    if (reset)                             overflow <= 1'b0;
    else if (tx_en && fifo_full && !pop)   overflow <= 1'b1;
    else if (clr_overflow)                 overflow <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (pop) begin
            shreg      <= mem[rd_ptr];
            parity_bit <= ~^mem[rd_ptr];
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            state   <= S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            state   <= S_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            if (pop) begin
              shreg      <= mem[rd_ptr];
              parity_bit <= ~^mem[rd_ptr];
              state      <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line and busy are registered from the state, so they trail it by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_serial <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_START:  tx_serial <= 1'b0;
        S_DATA:   tx_serial <= shreg[0];
        S_PARITY: tx_serial <= parity_bit;
        default:  tx_serial <= 1'b1;
      endcase
      busy <= (state != S_IDLE) || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx9.sv
// Directed self-checking bench for uart_tx9: one instance without parity,
// one with parity, both driven from the same stimulus.
module tb_uart_tx9;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] tx_data = '0;
  logic       tx_en = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       tx_serial, busy, full, overflow;
  logic       tx_serial_p, busy_p, full_p, overflow_p;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  uart_tx9 #(.CLKS_PER_BIT(16), .DEPTH(4), .PARITY_EN(0)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_en(tx_en),
    .clr_overflow(clr_overflow), .tx_serial(tx_serial), .busy(busy),
    .full(full), .overflow(overflow)
  );

  uart_tx9 #(.CLKS_PER_BIT(16), .DEPTH(4), .PARITY_EN(1)) dut_p (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_en(tx_en),
    .clr_overflow(clr_overflow), .tx_serial(tx_serial_p), .busy(busy_p),
    .full(full_p), .overflow(overflow_p)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected line level for frame bit k (0 = start) of word d.
  function automatic logic exp_bit(input logic [8:0] d, input int k, input bit par);
    if (k == 0) return 1'b0;
    if (k <= 9) return d[k-1];
    if (par && k == 10) return ~^d;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic do_reset();
    tx_en = 1'b0;
    clr_overflow = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (tx_serial !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx_serial: got %b expected 1", tx_serial); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++;
    if (tx_serial_p !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx_serial_p: got %b expected 1", tx_serial_p); end
  endtask

  task automatic test_single();
    int e0;
    logic [8:0] w = 9'h1A5;
    do_reset();
    tx_data = w; tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    e0 = edge_n;
    tick();
    vectors++;
    if (tx_serial !== 1'b1) begin miscompares++; $display("[TB] FAIL single_pop_cycle_line: got %b expected 1", tx_serial); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_early: got %b expected 1", busy); end
    for (int o = 0; o < 176; o++) begin
      tick_to(e0 + 2 + o);
      vectors++;
      if (tx_serial !== exp_bit(w, o / 16, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL single_frame cycle %0d: got %b expected %b", o, tx_serial, exp_bit(w, o / 16, 1'b0));
      end
    end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_last: got %b expected 1", busy); end
    tick_to(e0 + 178);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_done: got %b expected 0", busy); end
    vectors++;
    if (tx_serial !== 1'b1) begin miscompares++; $display("[TB] FAIL single_idle_line: got %b expected 1", tx_serial); end
  endtask

  task automatic test_parity();
    logic [8:0] pw [2] = '{9'h000, 9'h001};
    int e0;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      tx_data = pw[i]; tx_en = 1'b1;
      tick();
      tx_en = 1'b0;
      e0 = edge_n;
      for (int o = 0; o < 192; o++) begin
        tick_to(e0 + 2 + o);
        vectors++;
        if (tx_serial_p !== exp_bit(pw[i], o / 16, 1'b1)) begin
          miscompares++;
          $display("[TB] FAIL parity_frame word %h cycle %0d: got %b expected %b", pw[i], o, tx_serial_p, exp_bit(pw[i], o / 16, 1'b1));
        end
      end
      tick_to(e0 + 193);
      vectors++;
      if (busy_p !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_busy_last: got %b expected 1", busy_p); end
      tick_to(e0 + 194);
      vectors++;
      if (busy_p !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_busy_done: got %b expected 0", busy_p); end
    end
  endtask

  task automatic test_burst();
    logic [8:0] bw [6] = '{9'h101, 9'h0AA, 9'h155, 9'h0F0, 9'h1FF, 9'h033};
    int e0 = 0;
    int o;
    int lows = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tx_data = bw[i]; tx_en = 1'b1; clr_overflow = (i == 5);
      tick();
      if (i == 0) e0 = edge_n;
      if (i == 2) begin
        vectors++;
        if (tx_serial !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_first_start: got %b expected 0", tx_serial); end
      end
    end
    tx_en = 1'b0; clr_overflow = 1'b0;
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_overflow_set_over_clear: got %b expected 1", overflow); end
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_full: got %b expected 1", full); end
    for (int n = 6; n < 882; n++) begin
      tick_to(e0 + n);
      o = n - 2;
      vectors++;
      if (tx_serial !== exp_bit(bw[o / 176], (o % 176) / 16, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL burst_frames cycle %0d: got %b expected %b", o, tx_serial, exp_bit(bw[o / 176], (o % 176) / 16, 1'b0));
      end
    end
    tick_to(e0 + 882);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_busy_done: got %b expected 0", busy); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_full_drained: got %b expected 0", full); end
    for (int n = 0; n < 200; n++) begin
      tick();
      if (tx_serial !== 1'b1) lows++;
    end
    vectors++;
    if (lows !== 0) begin miscompares++; $display("[TB] FAIL burst_no_sixth_frame: got %0d low cycles expected 0", lows); end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_overflow_sticky: got %b expected 1", overflow); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_overflow_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [8:0] fw [6] = '{9'h011, 9'h122, 9'h033, 9'h144, 9'h055, 9'h1C6};
    int e0 = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_data = fw[i]; tx_en = 1'b1;
      tick();
      if (i == 0) e0 = edge_n;
    end
    tx_en = 1'b0;
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fullpop_full_before: got %b expected 1", full); end
    tick_to(e0 + 176);
    tx_data = fw[5]; tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpop_overflow: got %b expected 0", overflow); end
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL fullpop_full_after: got %b expected 1", full); end
    tick();
    vectors++;
    if (tx_serial !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpop_contiguous_start: got %b expected 0", tx_serial); end
    for (int o = 0; o < 176; o++) begin
      tick_to(e0 + 882 + o);
      vectors++;
      if (tx_serial !== exp_bit(fw[5], o / 16, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL fullpop_accepted_frame cycle %0d: got %b expected %b", o, tx_serial, exp_bit(fw[5], o / 16, 1'b0));
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fullpop_overflow_end: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] rw [3] = '{9'h0F0, 9'h123, 9'h0AB};
    int e0 = 0;
    int lows = 0;
    int busys = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_data = rw[i]; tx_en = 1'b1;
      tick();
      if (i == 0) e0 = edge_n;
    end
    tx_en = 1'b0;
    tick_to(e0 + 2 + 64 + 8);
    vectors++;
    if (tx_serial !== exp_bit(rw[0], 4, 1'b0)) begin miscompares++; $display("[TB] FAIL resetmid_bit4: got %b expected %b", tx_serial, exp_bit(rw[0], 4, 1'b0)); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (tx_serial !== 1'b1) begin miscompares++; $display("[TB] FAIL resetmid_line: got %b expected 1", tx_serial); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL resetmid_busy: got %b expected 0", busy); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL resetmid_full: got %b expected 0", full); end
    for (int n = 0; n < 400; n++) begin
      tick();
      if (tx_serial !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    vectors++;
    if (lows !== 0) begin miscompares++; $display("[TB] FAIL resetmid_no_frames: got %0d low cycles expected 0", lows); end
    vectors++;
    if (busys !== 0) begin miscompares++; $display("[TB] FAIL resetmid_stays_idle: got %0d busy cycles expected 0", busys); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] wa = 9'h0C3;
    logic [8:0] wb = 9'h13C;
    int e0;
    do_reset();
    tx_data = wa; tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    e0 = edge_n;
    for (int o = 0; o < 176; o++) begin
      if (o == 175) begin tx_data = wb; tx_en = 1'b1; end
      tick_to(e0 + 2 + o);
      tx_en = 1'b0;
      vectors++;
      if (tx_serial !== exp_bit(wa, o / 16, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL b2b_first_frame cycle %0d: got %b expected %b", o, tx_serial, exp_bit(wa, o / 16, 1'b0));
      end
    end
    tick_to(e0 + 178);
    vectors++;
    if (tx_serial !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle_gap: got %b expected 1", tx_serial); end
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy_gap: got %b expected 1", busy); end
    for (int o = 0; o < 176; o++) begin
      tick_to(e0 + 179 + o);
      vectors++;
      if (tx_serial !== exp_bit(wb, o / 16, 1'b0)) begin
        miscompares++;
        $display("[TB] FAIL b2b_second_frame cycle %0d: got %b expected %b", o, tx_serial, exp_bit(wb, o / 16, 1'b0));
      end
    end
    tick_to(e0 + 355);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_done: got %b expected 0", busy); end
  endtask

  initial begin
    $display("[TB] uart_tx9 directed bench starting");
    test_reset();
    test_single();
    test_parity();
    test_burst();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
